// File: rtl/mux4_arb_pkg.sv
// Shared types and the round-robin pick function for the 4-way mux arbiter.
// Pure combinational helpers, no state.
// Backpressure is not handled here; see mux4_rr_arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef struct packed {
        logic     found;
        req_idx_t idx;
    } pick_t;

    // Scan from ptr upward (mod NUM_REQ). Iterating far-to-near lets the
    // nearest valid requester overwrite any farther one.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                      input req_idx_t           ptr);
        pick_t    res;
        req_idx_t idx;
        res.found = 1'b0;
        res.idx   = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + req_idx_t'(k);
            if (valid[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 word multiplexer, sel 0..3 picks din1..din4.
// Latency: combinational.
// Backpressure: none, pure datapath.
module mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic [WIDTH-1:0] din4,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din1;
        unique case (sel)
            2'd0: dout = din1;
            2'd1: dout = din2;
            2'd2: dout = din3;
            2'd3: dout = din4;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering one of four valid/ready requesters through a mux4 into a one-entry output register.
// Latency: one cycle from grant edge to out_data; full throughput while out_ready is high.
// Backpressure: in_ready drops to zero whenever the output register is full and out_ready is low.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [WIDTH-1:0]   in_data1,
    input  logic [WIDTH-1:0]   in_data2,
    input  logic [WIDTH-1:0]   in_data3,
    input  logic [WIDTH-1:0]   in_data4,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    req_idx_t         out_sel_q,   out_sel_d;
    req_idx_t         ptr_q,       ptr_d;

    pick_t            pick;
    logic             any_valid;
    logic             load_en;
    logic             grant;
    logic [WIDTH-1:0] mux_dout;

    // any_valid is gated by reset so in_ready is zero while rst_n is low.
    always_comb begin
        pick      = rr_pick(in_valid, ptr_q);
        any_valid = pick.found && rst_n;
        load_en   = !out_valid_q || out_ready;
        grant     = load_en && any_valid;
    end

    always_comb begin
        in_ready = '0;
        if (grant) begin
            in_ready[pick.idx] = 1'b1;
        end
    end

    mux4 #(.WIDTH(WIDTH)) u_mux4 (
        .sel  (pick.idx),
        .din1 (in_data1),
        .din2 (in_data2),
        .din3 (in_data3),
        .din4 (in_data4),
        .dout (mux_dout)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (any_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = mux_dout;
                out_sel_d   = pick.idx;
                ptr_d       = pick.idx + 2'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: vector table of per-cycle handshakes plus a scoreboard of granted words.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [7:0] in_data1, in_data2, in_data3, in_data4;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_sel;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [1:0] exp_sel;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
    } sb_t;

    vec_t       vecs[21];
    sb_t        sbq[$];
    logic [7:0] last_data;
    logic [1:0] last_sel;

    mux4_rr_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_data4  (in_data4),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] word_of(input logic [1:0] s);
        case (s)
            2'd0:    return 8'hA1;
            2'd1:    return 8'hB2;
            2'd2:    return 8'hC3;
            default: return 8'hD4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven just after a rising edge; in_ready is sampled on the
    // falling edge and registered outputs just after the next rising edge.
    task automatic step(input logic [3:0] vld, input logic ordy,
                        input logic [3:0] exp_ir, input logic exp_ov,
                        input logic [1:0] exp_sel);
        sb_t e;
        in_valid  = vld;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        if (exp_ir != 4'b0000) begin
            sbq.push_back('{data: word_of(exp_sel), sel: exp_sel});
        end
        @(posedge clk);
        #1;
        if (exp_ir != 4'b0000) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: got empty queue expected entry");
            end else begin
                e         = sbq.pop_front();
                last_data = e.data;
                last_sel  = e.sel;
            end
        end
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("out_data",  32'(out_data),  32'(last_data));
        chk("out_sel",   32'(out_sel),   32'(last_sel));
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[5]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[9]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[10] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[13] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[14] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[15] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[16] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[18] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
        vecs[19] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        in_data1  = 8'hA1;
        in_data2  = 8'hB2;
        in_data3  = 8'hC3;
        in_data4  = 8'hD4;
        last_data = 8'h00;
        last_sel  = 2'd0;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_sel",   32'(out_sel),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rst_gated_in_ready", 32'(in_ready), 32'd0);

        @(posedge clk);
        #1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        rst_n     = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].vld, vecs[i].ordy, vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_sel);
        end

        // Reset asserted between edges while a word is held under stall.
        step(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
        step(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1);
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data",  32'(out_data),  32'd0);
        chk("midrst_out_sel",   32'(out_sel),   32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_data = 8'h00;
        last_sel  = 2'd0;
        sbq.delete();
        step(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
        step(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
        step(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter sharing one 4-input `mux4` datapath among four valid/ready requesters. Each cycle it selects one pending requester and steers that requester's word through the mux into a one-entry registered output stage. It sits in front of any single-consumer resource in the CPU datapath, such as a write-back port or a shared bus. It drives the mux `sel` itself and guarantees fair, starvation-free access.

## Interface
- `WIDTH`, default 8: data width of every requester and of the output.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  4: bit i is set when requester i (i=0..3) offers a word.
- `in_data1`..`in_data4`  in  WIDTH each: requester words 0..3, matching mux inputs `din1`..`din4`.
- `in_ready`  out  4: bit i means requester i's word is accepted this cycle.
- `out_valid`  out  1: the output register holds a word.
- `out_data`  out  WIDTH: the registered word.
- `out_sel`  out  2: index of the requester that supplied `out_data`.
- `out_ready`  in  1: the consumer accepts the word this cycle.

## Operation
- Handshake: a transfer occurs on any rising edge where valid and ready are both high. Requesters hold `in_data`/`in_valid` stable until accepted. The consumer may stall indefinitely.
- `load_en = !out_valid || out_ready`. The output register can take a new word when it is empty or is being drained in the same cycle.
- Priority pointer `ptr` (2 bits) marks the highest-priority requester.
- Winner: the first set bit of `in_valid`, scanning `ptr`, `ptr+1`, … mod 4.
- `in_ready[i] = load_en && any_valid && (winner == i)`. It is combinational and one-hot or zero. It never depends on `in_valid[j]` for j≠i beyond the winner scan.
- On a grant:
  - `out_data` ← mux4(winner).
  - `out_sel` ← winner.
  - `out_valid` ← 1.
  - `ptr` ← winner+1 mod 4 (wraps 3→0).
- If `load_en` is set and no requester is valid:
  - `out_valid` ← 0.
  - `out_data` and `out_sel` hold their last values.
  - `ptr` is unchanged.
- If `load_en` is low (stall):
  - `out_valid`, `out_data`, `out_sel` and `ptr` all hold.
  - `in_ready` = 0.
- Fairness: with all four requesters continuously valid, grants rotate 0,1,2,3,0,… Any valid requester waits at most 3 grants.
- State is the pointer plus the output register. There is no separate FSM. Conceptually there are two states:
  - EMPTY (`out_valid`=0): moves to FULL on any grant.
  - FULL: on a stall, stays FULL; on drain with a grant, stays FULL; on drain without a grant, moves to EMPTY.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0. `in_ready`=0 follows because `any_valid` is gated during reset.
- Latency: an accepted word appears on `out_data` one cycle after its grant edge.
- Throughput: one word per cycle while `out_ready`=1 and some requester is valid.
- Combinational paths: `in_valid`/`out_ready` → `in_ready` only. There is no path from input to `out_*`.
- Reset during a stalled transfer: the held word is discarded and `ptr` returns to 0. A requester that was still waiting is granted again after reset.

## Structure
- Package `mux4_arb_pkg` contains:
  - `NUM_REQ` = 4.
  - `typedef logic [1:0] req_idx_t` (used for `ptr`, winner and `out_sel`).
  - Function `rr_pick(valid, ptr)` returning the winner index plus a found flag.
- Sub-module: one instance of the existing `mux4 #(.WIDTH(WIDTH))`, with `sel` = winner and `din1`..`din4` = `in_data1`..`in_data4`.
- The remaining logic (pointer, output register, ready generation) sits in the top module.

## Test plan
- Reset, then all inputs 0 → `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0000.
- Only requester 2 valid with 8'hC3, `out_ready`=1 → `in_ready`=0100. Next cycle `out_data`=C3, `out_sel`=2. Repeated every cycle while held.
- All valid (A1,B2,C3,D4), `out_ready`=1 → `out_data` sequence A1,B2,C3,D4,A1 on consecutive cycles. `in_ready` rotates 0001,0010,0100,1000.
- All valid, `out_ready`=0 for 3 cycles after the first grant → `out_data`=A1 and `out_sel`=0 held, `in_ready`=0000 throughout. On release, B2 follows A1 with no gap.
- Requesters 1 and 3 valid with `ptr`=2 → requester 3 (D4) granted first, then 1 (B2). Pointer wraps 3→0.
- `rst_n` pulsed low mid-stall with `out_valid`=1 → `out_valid` drops immediately, with no clock needed. After release, requester 0 has priority.
